// File: rtl/rf_access_seq.sv
// rf_access_seq: sequences one register-file instruction at a time.
//   Accepts an instruction and reads its rs/rt operands from the register file.
//   Presents the operands to the execute stage.
//   If the instruction writes back, waits for the result and writes it to the
//   destination register.
//   Pulses Done when the instruction retires.
//
// Optional feature, selected at build time by the macro RF_ZERO_GUARD_EN:
//   defined   - a write to destination register 0 is suppressed (Done still pulses).
//   undefined - register 0 is written like any other register.
//
// Ports
//   CLK, RST           clock; synchronous active-high reset
//   Inst_valid/ready   instruction handshake; Inst (32b) and Wb_en sampled on accept
//   Op_valid/ready     operand handshake to execute; A = Mem[rs], B = Mem[rt]
//   Res_valid, Res     execute result, used only while waiting for it
//   R_reg1/2, R_data1/2  register file read ports (data is combinational)
//   W, W_reg, W_data   register file write port
//   Done               one-cycle retire pulse
module rf_access_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Inst_valid,
  output logic        Inst_ready,
  input  logic [31:0] Inst,
  input  logic        Wb_en,
  output logic        Op_valid,
  input  logic        Op_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic        Res_valid,
  input  logic [31:0] Res,
  output logic [4:0]  R_reg1,
  output logic [4:0]  R_reg2,
  input  logic [31:0] R_data1,
  input  logic [31:0] R_data2,
  output logic        W,
  output logic [4:0]  W_reg,
  output logic [31:0] W_data,
  output logic        Done
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StIssue,
    StWaitRes,
    StWrite
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q;
  logic        wb_en_q;
  logic [31:0] a_q, b_q, w_data_q;

  logic        idle_ready;
  logic        accept;
  logic        write_cyc;
  logic        done_cyc;
  logic [4:0]  dest;
  logic        write_allowed;

  // R-type (opcode 0) writes rd, everything else writes rt.
  assign dest = (inst_q[31:26] == 6'd0) ? inst_q[15:11] : inst_q[20:16];

`ifdef RF_ZERO_GUARD_EN
  assign write_allowed = (dest != 5'd0);
`else
  assign write_allowed = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      inst_q   <= '0;
      wb_en_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      w_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        inst_q  <= Inst;
        wb_en_q <= Wb_en;
      end
      if (state_q == StRead) begin
        a_q <= R_data1;
        b_q <= R_data2;
      end
      if ((state_q == StWaitRes) && Res_valid) begin
        w_data_q <= Res;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_ready = 1'b0;
    accept     = 1'b0;
    Op_valid   = 1'b0;
    write_cyc  = 1'b0;
    done_cyc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        idle_ready = 1'b1;
        if (Inst_valid) begin
          accept  = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StIssue;
      end
      StIssue: begin
        Op_valid = 1'b1;
        if (Op_ready) begin
          if (wb_en_q) begin
            state_d = StWaitRes;
          end else begin
            done_cyc = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StWaitRes: begin
        if (Res_valid) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        write_cyc = write_allowed;
        done_cyc  = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Reset abandons any in-flight instruction immediately: no accept, write or retire.
  assign Inst_ready = idle_ready & ~RST;
  assign W          = write_cyc & ~RST;
  assign Done       = done_cyc & ~RST;

  assign A      = a_q;
  assign B      = b_q;
  assign R_reg1 = inst_q[25:21];
  assign R_reg2 = inst_q[20:16];
  assign W_reg  = dest;
  assign W_data = w_data_q;

endmodule
